bs_spi_master: RTL and testbench

BS_SPI_MASTER -- requirements
Module: bs_spi_master

---
 rtl/bs_spi_master_if.sv | 27 ++
 rtl/bs_spi_master.sv | 116 +++++++++++
 tb/tb_bs_spi_master.sv | 306 ++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/bs_spi_master_if.sv
// Pin bundle for the Black-Scholes SPI master: operand handshake plus SPI pins.
// The master modport is the design side; slave is the driver/responder side.
interface bs_spi_master_if;
   logic        start;
   logic [15:0] S;
   logic [15:0] K;
   logic [15:0] r;
   logic [15:0] sigma;
   logic [15:0] T;
   logic        busy;
   logic        done;
   logic [15:0] call_price;
   logic        sck;
   logic        mosi;
   logic        cs;
   logic        miso;

   modport master (
      input  start, S, K, r, sigma, T, miso,
      output busy, done, call_price, sck, mosi, cs
   );

   modport slave (
      output start, S, K, r, sigma, T, miso,
      input  busy, done, call_price, sck, mosi, cs
   );
endinterface

// File: rtl/bs_spi_master.sv
// Black-Scholes SPI master: writes an 80-bit operand frame (mode 0, MSB first),
// holds cs high for WAIT_CYCLES, then reads back a 16-bit call price.
module bs_spi_master #(
   parameter int unsigned CLK_DIV     = 4,
   parameter int unsigned WAIT_CYCLES = 64
) (
   input  logic            clk,
   input  logic            rst,
   bs_spi_master_if.master bus
);
   typedef enum logic [2:0] {IDLE, TX, GAP, RX, FIN} state_t;

   localparam logic [7:0]  DIV_LAST  = 8'(CLK_DIV - 1);
   localparam logic [15:0] WAIT_LAST = 16'(WAIT_CYCLES - 1);
   localparam logic [7:0]  TX_LAST   = 8'd160;
   localparam logic [7:0]  RX_LAST   = 8'd32;

   state_t      r_state;
   logic [79:0] r_tx_shift;
   logic [15:0] r_rx_shift;
   logic [15:0] r_call_price;
   logic [15:0] r_wait_cnt;
   logic [7:0]  r_div_cnt;
   logic [7:0]  r_half_cnt;
   logic        r_sck;
   logic        r_cs;
   logic        r_busy;
   logic        r_done;

   logic        w_level_end;
   logic [7:0]  w_frame_last;

   // A frame is 2N+1 sck levels of CLK_DIV cycles: low lead-in, N periods, low tail.
   assign w_level_end  = (r_div_cnt == DIV_LAST);
   assign w_frame_last = (r_state == RX) ? RX_LAST : TX_LAST;

   always_ff @(posedge clk) begin
      if (rst) begin
         // NOTE: reset clears the shift registers too, so mosi (bit 79) reads 0 straight out of reset.
         r_state      <= IDLE;
         r_tx_shift   <= '0;
         r_rx_shift   <= '0;
         r_call_price <= '0;
         r_wait_cnt   <= '0;
         r_div_cnt    <= '0;
         r_half_cnt   <= '0;
         r_sck        <= 1'b0;
         r_cs         <= 1'b1;
         r_busy       <= 1'b0;
         r_done       <= 1'b0;
      end else begin
         r_done <= 1'b0;
         case (r_state)
            IDLE: begin
               if (bus.start) begin
                  r_tx_shift <= {bus.S, bus.K, bus.r, bus.sigma, bus.T};
                  r_state    <= TX;
                  r_cs       <= 1'b0;
                  r_busy     <= 1'b1;
                  r_div_cnt  <= '0;
                  r_half_cnt <= '0;
               end
            end
            TX, RX: begin
               if (r_cs) begin
                  // Only reached in RX: the cycle after cs rose publishes the result.
                  r_state      <= FIN;
                  r_done       <= 1'b1;
                  r_call_price <= r_rx_shift;
               end else if (!w_level_end) begin
                  r_div_cnt <= r_div_cnt + 8'd1;
               end else if (r_half_cnt == w_frame_last) begin
                  r_div_cnt <= '0;
                  r_cs      <= 1'b1;
                  if (r_state == TX) begin
                     r_state    <= GAP;
                     r_wait_cnt <= '0;
                  end
               end else begin
                  r_div_cnt  <= '0;
                  r_half_cnt <= r_half_cnt + 8'd1;
                  r_sck      <= ~r_sck;
                  if (r_sck) begin
                     r_tx_shift <= {r_tx_shift[78:0], 1'b0};
                  end else if (r_state == RX) begin
                     r_rx_shift <= {r_rx_shift[14:0], bus.miso};
                  end
               end
            end
            GAP: begin
               if (r_wait_cnt == WAIT_LAST) begin
                  r_state    <= RX;
                  r_cs       <= 1'b0;
                  r_div_cnt  <= '0;
                  r_half_cnt <= '0;
                  r_rx_shift <= '0;
               end else begin
                  r_wait_cnt <= r_wait_cnt + 16'd1;
               end
            end
            FIN: begin
               r_state <= IDLE;
               r_busy  <= 1'b0;
            end
            default: r_state <= IDLE;
         endcase
      end
   end

   assign bus.sck        = r_sck;
   assign bus.mosi       = r_tx_shift[79];
   assign bus.cs         = r_cs;
   assign bus.busy       = r_busy;
   assign bus.done       = r_done;
   assign bus.call_price = r_call_price;
endmodule

// File: tb/tb_bs_spi_master.sv
// Self-checking bench for bs_spi_master: three instances (CLK_DIV/WAIT 2/8, 1/1, 5/8)
// with a mode-0 responder and a frame monitor each, plus an expected-result queue.
module tb_bs_spi_master;
   typedef struct packed {
      logic [79:0] cap;
      int          w_tx;
      int          w_rx;
      int          gap;
      int          e_tx;
      int          e_rx;
      int          sck_err;
      int          mosi_err;
      int          done_cnt;
   } mon_t;

   typedef struct {
      int          g;
      logic [79:0] ops;
      logic [15:0] resp;
      logic [15:0] exp_price;
      int          lat;
      int          w_tx;
      int          w_rx;
      int          gap;
   } vec_t;

   typedef struct {
      int          g;
      logic [79:0] mosi;
      logic [15:0] price;
      int          done_cyc;
      int          w_tx;
      int          w_rx;
      int          gap;
   } exp_t;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   int          cyc = 0;
   int          n_vec = 0;
   int          n_err = 0;
   int          t_last = 0;

   logic        start_a    [3];
   logic [79:0] ops_a      [3];
   logic [15:0] resp_a     [3];
   logic [15:0] last_price [3];
   logic        done_a     [3];
   logic        busy_a     [3];
   logic        cs_a       [3];
   logic        sck_a      [3];
   logic        mosi_a     [3];
   logic [15:0] price_a    [3];
   mon_t        mon_a      [3];

   vec_t        vecs [4];
   exp_t        exp_q [$];

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   initial begin
      #500000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1);
   end

   for (genvar g = 0; g < 3; g++) begin : g_inst
      localparam int D = (g == 0) ? 2 : (g == 1) ? 1 : 5;
      localparam int W = (g == 1) ? 1 : 8;

      bs_spi_master_if u_bus ();
      mon_t        mon       = '0;
      logic [15:0] rsh       = '0;
      logic        miso_q    = 1'b0;
      logic        prev_cs   = 1'b1;
      logic        prev_sck  = 1'b0;
      logic        prev_mosi = 1'b0;
      logic        prev_busy = 1'b0;
      int          frame     = 0;
      int          e_cnt     = 0;
      int          fall_cyc  = 0;
      int          rise_cyc  = 0;

      bs_spi_master #(.CLK_DIV(D), .WAIT_CYCLES(W)) u_dut (
         .clk (clk),
         .rst (rst),
         .bus (u_bus)
      );

      assign u_bus.start = start_a[g];
      assign u_bus.S     = ops_a[g][79:64];
      assign u_bus.K     = ops_a[g][63:48];
      assign u_bus.r     = ops_a[g][47:32];
      assign u_bus.sigma = ops_a[g][31:16];
      assign u_bus.T     = ops_a[g][15:0];
      assign u_bus.miso  = miso_q;
      assign done_a[g]   = u_bus.done;
      assign busy_a[g]   = u_bus.busy;
      assign cs_a[g]     = u_bus.cs;
      assign sck_a[g]    = u_bus.sck;
      assign mosi_a[g]   = u_bus.mosi;
      assign price_a[g]  = u_bus.call_price;
      assign mon_a[g]    = mon;

      // Mode-0 responder: MSB valid when cs falls, next bit after each sck fall.
      always @(negedge clk) begin
         if (!u_bus.cs && prev_cs) begin
            miso_q <= resp_a[g][15];
            rsh    <= resp_a[g] << 1;
         end else if (!u_bus.sck && prev_sck) begin
            miso_q <= rsh[15];
            rsh    <= rsh << 1;
         end
      end

      always @(negedge clk) begin
         prev_cs   <= u_bus.cs;
         prev_sck  <= u_bus.sck;
         prev_mosi <= u_bus.mosi;
         prev_busy <= u_bus.busy;
         if (u_bus.busy && !prev_busy) begin
            mon      <= '0;
            frame    <= 1;
            e_cnt    <= 0;
            fall_cyc <= cyc;
         end else begin
            if (u_bus.sck != prev_sck && u_bus.cs) mon.sck_err <= mon.sck_err + 1;
            if (u_bus.sck && !prev_sck) begin
               e_cnt <= e_cnt + 1;
               if (u_bus.mosi != prev_mosi) mon.mosi_err <= mon.mosi_err + 1;
               if (frame == 1) mon.cap <= {mon.cap[78:0], u_bus.mosi};
            end
            if (!u_bus.cs && prev_cs) begin
               frame    <= frame + 1;
               e_cnt    <= 0;
               fall_cyc <= cyc;
               if (frame == 1) mon.gap <= cyc - rise_cyc;
            end
            if (u_bus.cs && !prev_cs) begin
               rise_cyc <= cyc;
               if (frame == 1) begin
                  mon.w_tx <= cyc - fall_cyc;
                  mon.e_tx <= e_cnt;
               end else if (frame == 2) begin
                  mon.w_rx <= cyc - fall_cyc;
                  mon.e_rx <= e_cnt;
               end
            end
            if (u_bus.done) mon.done_cnt <= mon.done_cnt + 1;
         end
      end
   end

   task automatic check(input string name, input logic [79:0] act, input logic [79:0] exp_v);
      n_vec++;
      if (act !== exp_v) begin
         n_err++;
         $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp_v, cyc);
      end
   endtask

   // Called right after a negedge; start is seen by the following posedge.
   task automatic start_txn(input vec_t v);
      exp_t e;
      ops_a[v.g]  = v.ops;
      resp_a[v.g] = v.resp;
      start_a[v.g] = 1'b1;
      t_last     = cyc;
      e.g        = v.g;
      e.mosi     = v.ops;
      e.price    = v.exp_price;
      e.done_cyc = cyc + v.lat;
      e.w_tx     = v.w_tx;
      e.w_rx     = v.w_rx;
      e.gap      = v.gap;
      exp_q.push_back(e);
      @(negedge clk);
      start_a[v.g] = 1'b0;
   endtask

   task automatic wait_done(output int g);
      exp_t e;
      int   t_done;
      int   hold_bad;
      e        = exp_q.pop_front();
      g        = e.g;
      t_done   = -1;
      hold_bad = 0;
      for (int i = 0; i < 3000; i++) begin
         if (done_a[e.g]) begin
            t_done = cyc;
            break;
         end
         if (price_a[e.g] !== last_price[e.g]) hold_bad++;
         @(negedge clk);
      end
      check("done_cycle",   t_done, e.done_cyc);
      check("call_price",   price_a[e.g], e.price);
      check("price_hold",   hold_bad, 0);
      check("busy_in_fin",  busy_a[e.g], 1'b1);
      check("mosi_stream",  mon_a[e.g].cap, e.mosi);
      check("cs_low_tx",    mon_a[e.g].w_tx, e.w_tx);
      check("cs_low_rx",    mon_a[e.g].w_rx, e.w_rx);
      check("cs_high_gap",  mon_a[e.g].gap, e.gap);
      check("sck_rises_tx", mon_a[e.g].e_tx, 80);
      check("sck_rises_rx", mon_a[e.g].e_rx, 16);
      check("sck_while_cs", mon_a[e.g].sck_err, 0);
      check("mosi_at_rise", mon_a[e.g].mosi_err, 0);
      last_price[e.g] = e.price;
   endtask

   task automatic finish_txn();
      int g;
      wait_done(g);
      @(negedge clk);
      check("done_one_cycle", done_a[g], 1'b0);
      check("busy_after_fin", busy_a[g], 1'b0);
      check("done_count",     mon_a[g].done_cnt, 1);
   endtask

   initial begin
      vec_t v;
      exp_t dropped;
      int   n_done;
      int   g0;

      vecs[0] = '{0, 80'h1000_0F00_0050_0333_0100, 16'h0234, 16'h0234, 398, 322, 66, 8};
      vecs[1] = '{0, 80'hFFFF_0001_8000_AAAA_5555, 16'h8001, 16'h8001, 398, 322, 66, 8};
      vecs[2] = '{1, 80'h1000_0F00_0050_0333_0100, 16'h0234, 16'h0234, 197, 161, 33, 1};
      vecs[3] = '{2, 80'h1000_0F00_0050_0333_0100, 16'h0234, 16'h0234, 980, 805, 165, 8};

      for (int g = 0; g < 3; g++) begin
         start_a[g]    = 1'b0;
         ops_a[g]      = '0;
         resp_a[g]     = '0;
         last_price[g] = '0;
      end

      // Reset with start held on instance 0: start must be ignored.
      start_a[0] = 1'b1;
      ops_a[0]   = 80'h1234_5678_9ABC_DEF0_1357;
      repeat (3) @(negedge clk);
      rst        = 1'b0;
      start_a[0] = 1'b0;
      @(negedge clk);
      for (int g = 0; g < 3; g++) begin
         check("rst_cs",    cs_a[g],    1'b1);
         check("rst_sck",   sck_a[g],   1'b0);
         check("rst_mosi",  mosi_a[g],  1'b0);
         check("rst_busy",  busy_a[g],  1'b0);
         check("rst_done",  done_a[g],  1'b0);
         check("rst_price", price_a[g], 16'h0000);
      end

      for (int i = 0; i < 4; i++) begin
         start_txn(vecs[i]);
         finish_txn();
      end

      // Start with different operands in the middle of the write frame.
      start_txn(vecs[0]);
      repeat (50) @(negedge clk);
      ops_a[0]   = 80'hDEAD_BEEF_CAFE_F00D_5A5A;
      start_a[0] = 1'b1;
      @(negedge clk);
      start_a[0] = 1'b0;
      finish_txn();

      // Reset during the 8th read bit (seg 15 of the read frame starts 361 cycles in).
      start_txn(vecs[1]);
      while (cyc < t_last + 361) @(negedge clk);
      check("rx8_cs_low",  cs_a[0],  1'b0);
      check("rx8_sck_high", sck_a[0], 1'b1);
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      check("abort_cs",    cs_a[0],    1'b1);
      check("abort_busy",  busy_a[0],  1'b0);
      check("abort_price", price_a[0], 16'h0000);
      check("abort_done",  done_a[0],  1'b0);
      dropped = exp_q.pop_front();
      for (int g = 0; g < 3; g++) last_price[g] = '0;
      n_done = 0;
      for (int i = 0; i < 500; i++) begin
         @(negedge clk);
         if (done_a[0]) n_done++;
      end
      check("abort_no_done", n_done, 0);
      start_txn(vecs[0]);
      finish_txn();

      // Back-to-back: second start in the cycle after FIN.
      start_txn(vecs[1]);
      wait_done(g0);
      @(negedge clk);
      v           = vecs[0];
      v.resp      = 16'hFFFF;
      v.exp_price = 16'hFFFF;
      start_txn(v);
      finish_txn();

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end
endmodule
